led_pattern_gen: RTL



---
 rtl/led_pattern_gen.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// LED target-pattern generator for the reaction game: shows an LFSR-derived 3-bit
// pattern for a shrinking window, strobes check, accumulates hits into a score.
module led_pattern_gen #(
  parameter logic [7:0]  SEED         = 8'hA5,
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned DISPLAY_INIT = 50000000,
  parameter int unsigned DISPLAY_STEP = 5000000,
  parameter int unsigned DISPLAY_MIN  = 10000000,
  parameter int unsigned GAP_TICKS    = 25000000,
  parameter int unsigned TIMER_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  output logic [2:0] led,
  output logic       led_valid,
  output logic       check,
  output logic [3:0] round_cnt,
  output logic [3:0] score,
  output logic       busy,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_CHECK,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [TIMER_W-1:0] INIT_T = TIMER_W'(DISPLAY_INIT);
  localparam logic [TIMER_W-1:0] STEP_T = TIMER_W'(DISPLAY_STEP);
  localparam logic [TIMER_W-1:0] MIN_T  = TIMER_W'(DISPLAY_MIN);
  localparam logic [TIMER_W-1:0] GAP_T  = TIMER_W'(GAP_TICKS);
  localparam logic [3:0]         LAST_R = 4'(NUM_ROUNDS);

  state_e              state_q, state_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [TIMER_W-1:0]  window_q, window_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [2:0]          led_q, led_d;
  logic                led_valid_q, led_valid_d;
  logic                check_q, check_d;
  logic [3:0]          round_q, round_d;
  logic [3:0]          score_q, score_d;
  logic                busy_q, busy_d;
  logic                game_over_q, game_over_d;

  logic [7:0]          lfsr_next;
  logic [2:0]          pattern;
  logic [TIMER_W-1:0]  window_dec;
  logic [TIMER_W-1:0]  timer_dec;
  logic [3:0]          round_inc;
  logic [3:0]          score_inc;

  always_comb begin
    lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    pattern   = (lfsr_q[2:0] == 3'b000) ? 3'b001 : lfsr_q[2:0];
    // Subtract only when the result stays at or above the floor; avoids wrap.
    window_dec = ((window_q >= STEP_T) && ((window_q - STEP_T) >= MIN_T))
                 ? (window_q - STEP_T) : MIN_T;
    timer_dec  = (timer_q != '0) ? (timer_q - 1'b1) : '0;
    round_inc  = (round_q == 4'hF) ? round_q : (round_q + 4'd1);
    score_inc  = (score_q == 4'hF) ? score_q : (score_q + 4'd1);
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    window_d = window_q;
    timer_d  = timer_q;
    led_d    = led_q;
    round_d  = round_q;
    score_d  = score_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SHOW;
          round_d  = '0;
          score_d  = '0;
          window_d = INIT_T;
          timer_d  = INIT_T;
          led_d    = pattern;
          lfsr_d   = lfsr_next;
        end
      end
      S_SHOW: begin
        timer_d = timer_dec;
        if (timer_q <= TIMER_W'(1)) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        round_d  = round_inc;
        window_d = window_dec;
        led_d    = '0;
        if (hit) begin
          score_d = score_inc;
        end
        if (round_inc == LAST_R) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GAP;
          timer_d = GAP_T;
        end
      end
      S_GAP: begin
        timer_d = timer_dec;
        if (timer_q <= TIMER_W'(1)) begin
          state_d = S_SHOW;
          timer_d = window_q;
          led_d   = pattern;
          lfsr_d  = lfsr_next;
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = '0;
      end
    endcase

    // Status outputs are decoded from the next state so they register in step with it.
    led_valid_d = (state_d == S_SHOW) || (state_d == S_CHECK);
    check_d     = (state_d == S_CHECK);
    busy_d      = (state_d == S_SHOW) || (state_d == S_CHECK) || (state_d == S_GAP);
    game_over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      window_q    <= INIT_T;
      timer_q     <= '0;
      led_q       <= '0;
      led_valid_q <= 1'b0;
      check_q     <= 1'b0;
      round_q     <= '0;
      score_q     <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      window_q    <= window_d;
      timer_q     <= timer_d;
      led_q       <= led_d;
      led_valid_q <= led_valid_d;
      check_q     <= check_d;
      round_q     <= round_d;
      score_q     <= score_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign led       = led_q;
  assign led_valid = led_valid_q;
  assign check     = check_q;
  assign round_cnt = round_q;
  assign score     = score_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;

  a_check_single: assert property (@(posedge clk) disable iff (!rst) check_q |=> !check_q);
  a_led_live:     assert property (@(posedge clk) disable iff (!rst) led_valid_q |-> (led_q != 3'b000));

endmodule
